// File: rtl/encoder_4x2_queued.sv
// encoder_4x2_queued
//   Queued request encoder. Request lines are OR-ed into a pending register and
//   served one at a time as a binary code through a valid/ready output stage, so
//   simultaneous requests are never lost. Default selection is fixed priority
//   (highest set index wins).
//
//   Optional feature macro: ROUND_ROBIN_EN
//     When defined, selection rotates: the search starts at rr_ptr and wraps
//     upward; after each load rr_ptr moves to one past the served index.
//
// Ports
//   clk      in   1       rising-edge clock
//   rst_n    in   1       asynchronous active-low reset
//   En       in   1       request capture enable (D ignored when 0)
//   D        in   N_IN    request vector, any number of bits may be set
//   Y        out  CODE_W  encoded index of the served request
//   Y_valid  out  1       Y holds a served code
//   Y_ready  in   1       consumer accepts Y this cycle
//   dup      out  1       one-cycle pulse: captured bit was already pending
//   idle     out  1       nothing pending and Y_valid low
module encoder_4x2_queued #(
  parameter int N_IN   = 4,
  parameter int CODE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              En,
  input  logic [N_IN-1:0]   D,
  output logic [CODE_W-1:0] Y,
  output logic              Y_valid,
  input  logic              Y_ready,
  output logic              dup,
  output logic              idle
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     p_q, p_d;
  logic [CODE_W-1:0]   y_q, y_d;
  logic                dup_q, dup_d;
  logic [CODE_W-1:0]   sel_idx;
  logic                load;
  logic [N_IN-1:0]     clr;

`ifdef ROUND_ROBIN_EN
  logic [CODE_W-1:0]   rr_q, rr_d;

  // Walk offsets from the far end down to 0 so the smallest offset from ptr
  // (i.e. the first hit in wrap-around order) is the one that sticks.
  function automatic logic [CODE_W-1:0] sel_rr(input logic [N_IN-1:0]   p,
                                               input logic [CODE_W-1:0] ptr);
    logic [CODE_W-1:0] r;
    logic [CODE_W-1:0] idx;
    r = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      idx = CODE_W'(int'(ptr) + k);
      if (p[idx]) r = idx;
    end
    return r;
  endfunction
`else
  // Ascending scan: the last hit is the highest set index.
  function automatic logic [CODE_W-1:0] sel_fixed(input logic [N_IN-1:0] p);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (p[i]) r = CODE_W'(i);
    end
    return r;
  endfunction
`endif

  always_comb begin
`ifdef ROUND_ROBIN_EN
    sel_idx = sel_rr(p_q, rr_q);
`else
    sel_idx = sel_fixed(p_q);
`endif
    // A new code is taken when something is pending and the output slot is
    // empty or being emptied this cycle.
    load    = (p_q != '0) && ((state_q == EMPTY) || Y_ready);
    clr     = load ? (N_IN'(1) << sel_idx) : '0;
    // Set is OR-ed after the clear, so a request arriving on the bit being
    // served stays pending.
    p_d     = (p_q & ~clr) | (En ? D : '0);
    dup_d   = En & (|(D & p_q & ~clr));
    y_d     = y_q;
    state_d = state_q;
    if (load) begin
      y_d     = sel_idx;
      state_d = FULL;
    end else if (state_q == FULL && Y_ready) begin
      state_d = EMPTY;
    end
`ifdef ROUND_ROBIN_EN
    rr_d = load ? (sel_idx + CODE_W'(1)) : rr_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      p_q     <= '0;
      y_q     <= '0;
      dup_q   <= 1'b0;
`ifdef ROUND_ROBIN_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      y_q     <= y_d;
      dup_q   <= dup_d;
`ifdef ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign Y       = y_q;
  assign Y_valid = (state_q == FULL);
  assign dup     = dup_q;
  assign idle    = (p_q == '0) && (state_q == EMPTY);

endmodule

// File: tb/tb_encoder_4x2_queued.sv
// Directed testbench for encoder_4x2_queued (N_IN=4, CODE_W=2).
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_encoder_4x2_queued;

  logic       clk;
  logic       rst_n;
  logic       En;
  logic [3:0] D;
  logic [1:0] Y;
  logic       Y_valid;
  logic       Y_ready;
  logic       dup;
  logic       idle;

  int n_chk;
  int n_fail;

  encoder_4x2_queued #(.N_IN(4), .CODE_W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .En      (En),
    .D       (D),
    .Y       (Y),
    .Y_valid (Y_valid),
    .Y_ready (Y_ready),
    .dup     (dup),
    .idle    (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    En      = 1'b1;
    D       = 4'b1111;
    Y_ready = 1'b0;

    // 1: reset held with all requests asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", 32'(Y_valid), 32'd0);
      chk("rst_idle",  32'(idle),    32'd1);
    end
    chk("rst_Y",   32'(Y),   32'd0);
    chk("rst_dup", 32'(dup), 32'd0);
    En = 1'b0; D = 4'b0000; rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(Y_valid), 32'd0);
    chk("post_rst_idle",  32'(idle),    32'd1);

    // 2: single request
    En = 1'b1; D = 4'b0100; Y_ready = 1'b1;
    tick();
    chk("t2_cap_valid", 32'(Y_valid), 32'd0);
    chk("t2_cap_idle",  32'(idle),    32'd0);
    En = 1'b0; D = 4'b0000;
    tick();
    chk("t2_Y",     32'(Y),       32'd2);
    chk("t2_valid", 32'(Y_valid), 32'd1);
    tick();
    chk("t2_done_valid", 32'(Y_valid), 32'd0);
    chk("t2_done_idle",  32'(idle),    32'd1);

    // 3: multi request, fixed priority
    En = 1'b1; D = 4'b1011;
    tick();
    En = 1'b0; D = 4'b0000;
    tick();
    chk("t3_Y0", 32'(Y), 32'd3);
    chk("t3_v0", 32'(Y_valid), 32'd1);
    tick();
    chk("t3_Y1", 32'(Y), 32'd1);
    chk("t3_v1", 32'(Y_valid), 32'd1);
    tick();
    chk("t3_Y2", 32'(Y), 32'd0);
    chk("t3_v2", 32'(Y_valid), 32'd1);
    tick();
    chk("t3_end_valid", 32'(Y_valid), 32'd0);

    // 4: backpressure
    En = 1'b1; D = 4'b0011; Y_ready = 1'b0;
    tick();
    En = 1'b0; D = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_Y", 32'(Y),       32'd1);
      chk("t4_hold_v", 32'(Y_valid), 32'd1);
    end
    Y_ready = 1'b1;
    tick();
    chk("t4_next_Y", 32'(Y),       32'd0);
    chk("t4_next_v", 32'(Y_valid), 32'd1);
    tick();
    chk("t4_end_idle", 32'(idle), 32'd1);

    // 5a: duplicate of a pending bit is merged
    En = 1'b1; D = 4'b0011; Y_ready = 1'b0;
    tick();
    En = 1'b0; D = 4'b0000;
    tick();
    chk("t5a_Y", 32'(Y), 32'd1);
    En = 1'b1; D = 4'b0001;
    tick();
    chk("t5a_dup", 32'(dup), 32'd1);
    En = 1'b0; D = 4'b0000;
    tick();
    chk("t5a_dup_clr", 32'(dup), 32'd0);
    Y_ready = 1'b1;
    tick();
    chk("t5a_Y0", 32'(Y),       32'd0);
    chk("t5a_v0", 32'(Y_valid), 32'd1);
    tick();
    chk("t5a_once_valid", 32'(Y_valid), 32'd0);
    chk("t5a_once_idle",  32'(idle),    32'd1);

    // 5b: set wins over clear on the loading edge
    En = 1'b1; D = 4'b0001;
    tick();
    tick();
    chk("t5b_Y",    32'(Y),       32'd0);
    chk("t5b_v",    32'(Y_valid), 32'd1);
    chk("t5b_dup",  32'(dup),     32'd0);
    chk("t5b_idle", 32'(idle),    32'd0);
    En = 1'b0; D = 4'b0000;
    tick();
    chk("t5b_again_Y", 32'(Y),       32'd0);
    chk("t5b_again_v", 32'(Y_valid), 32'd1);
    tick();
    chk("t5b_end_idle", 32'(idle), 32'd1);

    // Reset mid-operation discards pending and unconsumed output
    En = 1'b1; D = 4'b1010; Y_ready = 1'b0;
    tick();
    En = 1'b0; D = 4'b0000;
    tick();
    chk("mid_pre_v", 32'(Y_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_async_v",    32'(Y_valid), 32'd0);
    chk("mid_async_idle", 32'(idle),    32'd1);
    tick();
    rst_n = 1'b1; Y_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_after_v", 32'(Y_valid), 32'd0);
    end

    // 6: all requests re-asserted each cycle
    En = 1'b1; D = 4'b1111;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_v", 32'(Y_valid), 32'd1);
`ifdef ROUND_ROBIN_EN
      chk("t6_Y", 32'(Y), 32'(i % 4));
`else
      chk("t6_Y", 32'(Y), 32'd3);
`endif
    end
    En = 1'b0; D = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
